// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and the sequencer state type.
package alu_arb_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner selection between two requesters.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN makes requester 0 always win ties.
module alu_arb_pick (
    input  logic valid0,
    input  logic valid1,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic last_grant,
`endif
    output logic grant_any,
    output logic winner
);

    always_comb begin
        grant_any = valid0 | valid1;
        winner    = 1'b0;
        if (valid0 && valid1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
        end else if (valid1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-client sequencer sharing one external MIPS ALU: grant, execute, respond.
// Optional ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,

    output logic [CTL_W-1:0] alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    state_t             state_reg;
    logic [CTL_W-1:0]   ctl_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               id_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               grant_any;
    logic               winner;
    logic               accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic               last_grant_reg;
`endif

    alu_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .last_grant (last_grant_reg),
`endif
        .grant_any  (grant_any),
        .winner     (winner)
    );

    // Grants are only offered in IDLE and never while reset is being applied.
    assign accept     = (state_reg == IDLE) && grant_any && !reset;
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ctl_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        ctl_reg        <= winner ? req1_ctl : req0_ctl;
                        a_reg          <= winner ? req1_a   : req0_a;
                        b_reg          <= winner ? req1_b   : req0_b;
                        id_reg         <= winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_reg <= winner;
`endif
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_out;
                    zero_reg   <= alu_zero;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_ctl     = ctl_reg;
    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign resp_valid  = (state_reg == RESP);
    assign resp_id     = id_reg;
    assign resp_result = result_reg;
    assign resp_zero   = zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural MIPS ALU attached to the shared port.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH = 32;
    localparam int CTL_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [CTL_W-1:0] req0_ctl, req1_ctl;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             resp_valid, resp_ready, resp_id, resp_zero;
    logic [WIDTH-1:0] resp_result;
    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_zero;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .CTL_W(CTL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctl    (req0_ctl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctl    (req1_ctl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_ctl     (alu_ctl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero)
    );

    // Behavioural MIPS ALU
    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_SLT: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_out = ~(alu_a | alu_b);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per response handshake
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_resp: got id=%0d result=%0h, required no response",
                         resp_id, resp_result);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp id=%0d result=%0h zero=%0d (required id=%0d result=%0h zero=%0d)",
                         resp_id, resp_result, resp_zero, mon_e.id, mon_e.result, mon_e.zero);
                check("resp_id", {63'd0, resp_id}, {63'd0, mon_e.id});
                check("resp_result", {32'd0, resp_result}, {32'd0, mon_e.result});
                check("resp_zero", {63'd0, resp_zero}, {63'd0, mon_e.zero});
            end
        end
    end

    // Waits (bounded) for a grant; returns at posedge+1 of the accepting edge.
    task automatic wait_grant(output int who, output int cycles);
        who = -1;
        cycles = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cycles++;
            if (req0_ready) begin who = 0; break; end
            if (req1_ready) begin who = 1; break; end
        end
        if (who < 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL grant_timeout: got no grant in 20 cycles, required a grant");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [WIDTH-1:0] res, input logic z);
        exp_t e;
        e.id = id;
        e.result = res;
        e.zero = z;
        exp_q.push_back(e);
    endtask

    initial begin
        int who, cyc;
        int exp_seq [4];
        reset = 1'b1;
        req0_valid = 1'b1; req0_ctl = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b1;

        // Reset state, with a request held during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_id", {63'd0, resp_id}, 64'd0);
        check("rst_resp_result", {32'd0, resp_result}, 64'd0);
        check("rst_resp_zero", {63'd0, resp_zero}, 64'd0);
        check("rst_alu_ctl", {60'd0, alu_ctl}, 64'd0);
        check("rst_alu_a", {32'd0, alu_a}, 64'd0);
        check("rst_alu_b", {32'd0, alu_b}, 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b0;

        // Single request: ADD 0xA + 0x5
        push(1'b0, 32'hF, 1'b0);
        req0_valid = 1'b1; req0_ctl = ALU_ADD; req0_a = 32'hA; req0_b = 32'h5;
        wait_grant(who, cyc);
        $display("single: grant=%0d", who);
        check("single_grant", who, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        check("lat_exec_valid", {63'd0, resp_valid}, 64'd0);
        check("lat_alu_a", {32'd0, alu_a}, 64'hA);
        @(negedge clk);
        check("lat_resp_valid", {63'd0, resp_valid}, 64'd1);
        @(posedge clk); #1;

        // Both valid from reset: SUB 5-5 vs SLT 0xA<0x5
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) push(exp_seq[k] != 0, 32'h0, 1'b1);
        req0_valid = 1'b1; req0_ctl = ALU_SUB; req0_a = 32'd5; req0_b = 32'd5;
        req1_valid = 1'b1; req1_ctl = ALU_SLT; req1_a = 32'hA; req1_b = 32'h5;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, cyc);
            $display("both_valid: grant %0d -> requester %0d", k, who);
            check("arb_grant", who, exp_seq[k]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Backpressure: AND held in RESP while OR waits
        resp_ready = 1'b0;
        push(1'b0, 32'h0, 1'b1);
        req0_valid = 1'b1; req0_ctl = ALU_AND; req0_a = 32'hA; req0_b = 32'h5;
        wait_grant(who, cyc);
        check("bp_grant", who, 0);
        req0_valid = 1'b0;
        push(1'b1, 32'hF, 1'b0);
        req1_valid = 1'b1; req1_ctl = ALU_OR; req1_a = 32'hA; req1_b = 32'h5;
        cyc = 0;
        while (!resp_valid && cyc < 10) begin @(negedge clk); cyc++; end
        check("bp_resp_seen", {63'd0, resp_valid}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            $display("backpressure cycle %0d: valid=%0d id=%0d result=%0h r0=%0d r1=%0d",
                     k, resp_valid, resp_id, resp_result, req0_ready, req1_ready);
            check("bp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_id", {63'd0, resp_id}, 64'd0);
            check("bp_result", {32'd0, resp_result}, 64'd0);
            check("bp_zero", {63'd0, resp_zero}, 64'd1);
            check("bp_ready1", {63'd0, req1_ready}, 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        wait_grant(who, cyc);
        $display("after backpressure: grant=%0d after %0d cycles", who, cyc);
        check("bp_next_grant", who, 1);
        check("bp_next_delay", cyc, 1);
        req1_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset during EXEC discards the op
        req0_valid = 1'b1; req0_ctl = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
        wait_grant(who, cyc);
        check("rx_grant", who, 0);
        reset = 1'b1;
        req0_ctl = ALU_ADD; req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1'b1; req1_ctl = ALU_NOR; req1_a = 32'd0; req1_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("rx_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rx_ready0", {63'd0, req0_ready}, 64'd0);
        check("rx_ready1", {63'd0, req1_ready}, 64'd0);
        check("rx_alu_a", {32'd0, alu_a}, 64'd0);
        push(1'b0, 32'd7, 1'b0);
        push(1'b1, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_grant(who, cyc);
        $display("after reset: first grant=%0d after %0d cycles", who, cyc);
        check("rx_first_grant", who, 0);
        check("rx_first_delay", cyc, 1);
        req0_valid = 1'b0;
        wait_grant(who, cyc);
        check("rx_second_grant", who, 1);
        req1_valid = 1'b0;

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin @(posedge clk); cyc++; end
        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
